// File: rtl/instr_seq.sv
// instr_seq: fetch/execute sequencer with instruction decode, carry/zero flags and retired-instruction count.
// Optional ILLEGAL_TRAP_EN: undefined opcodes halt the machine instead of decoding as nop.
module instr_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ir,
    input  logic             start,
    input  logic             alu_cf,
    input  logic             alu_zf,
    input  logic             cf_en,
    input  logic             zf_en,
    output logic             sm,
    output logic             mova,
    output logic             movb,
    output logic             movc,
    output logic             add,
    output logic             sub,
    output logic             and1,
    output logic             not1,
    output logic             rsr,
    output logic             rsl,
    output logic             jmp,
    output logic             jz,
    output logic             jc,
    output logic             in1,
    output logic             out1,
    output logic             nop,
    output logic             halt,
    output logic             c,
    output logic             z,
    output logic             illegal,
    output logic [CNT_W-1:0] icnt
);
    // Bit 1 of the state is the sm beat, so sm comes straight off a flop.
    localparam logic [1:0] S_FETCH = 2'b00;
    localparam logic [1:0] S_EXEC  = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic [1:0]       state_q, state_d;
    logic             c_q, c_d, z_q, z_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [3:0]       op;
    logic             exec, bad, to_halt;

    assign op      = ir[7:4];
    assign exec    = state_q == S_EXEC;
    assign bad     = (op == 4'h8) || (op >= 4'hD) || (op == 4'h4 && ir[3:2] == 2'b11);
    assign illegal = TRAP && exec && bad;
    assign to_halt = exec && (op == 4'h1 || (TRAP && bad));
    assign sm      = state_q[1];
    assign c       = c_q;
    assign z       = z_q;
    assign icnt    = icnt_q;

    always_comb begin
        {mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt} = '0;
        if (state_q == S_HALT) begin
            halt = 1'b1;
        end else if (exec) begin
            case (op)
                4'h0: nop  = 1'b1;
                4'h1: halt = 1'b1;
                4'h2: in1  = 1'b1;
                4'h3: out1 = 1'b1;
                4'h4: begin
                    jmp = ir[3:2] == 2'b00;
                    jz  = ir[3:2] == 2'b01;
                    jc  = ir[3:2] == 2'b10;
                    nop = ir[3:2] == 2'b11 && !TRAP;
                end
                4'h5: not1 = 1'b1;
                4'h6: sub  = 1'b1;
                4'h7: begin
                    movb = ir[3:2] == 2'b11;
                    movc = ir[3:2] != 2'b11 && ir[1:0] == 2'b11;
                    mova = ir[3:2] != 2'b11 && ir[1:0] != 2'b11;
                end
                4'h9: add  = 1'b1;
                4'hA: rsr  = 1'b1;
                4'hB: and1 = 1'b1;
                4'hC: rsl  = 1'b1;
                default: nop = !TRAP;
            endcase
        end
    end

    always_comb begin
        state_d = exec ? (to_halt ? S_HALT : S_FETCH)
                : state_q == S_HALT ? (start ? S_FETCH : S_HALT) : S_EXEC;
        c_d     = exec && cf_en ? alu_cf : c_q;
        z_d     = exec && zf_en ? alu_zf : z_q;
        icnt_d  = exec ? icnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : icnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            z_q     <= z_d;
            icnt_q  <= icnt_d;
        end
    end
endmodule

// File: doc/instr_seq.md
# instr_seq

Fetch/execute sequencer and instruction decoder for the model machine. It owns the `sm` beat, the halted state and the latched carry/zero flags. It decodes the 8-bit instruction register into the one-hot instruction lines consumed by `con_signal`. It sits between the IR and `con_signal`, and receives the flag enables back from `con_signal` and the raw flags from the ALU.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk  input  1`: system clock, rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `ir  input  8`: instruction register contents, stable during EXEC.
- `start  input  1`: single-cycle pulse; resumes from HALT.
- `alu_cf`, `alu_zf  input  1 each`: raw ALU carry and zero.
- `cf_en`, `zf_en  input  1 each`: flag-write enables from `con_signal`.
- `sm  output  1`: 0 = fetch beat, 1 = execute beat.
- `mova`, `movb`, `movc`, `add`, `sub`, `and1`, `not1`, `rsr`, `rsl`, `jmp`, `jz`, `jc`, `in1`, `out1`, `nop`, `halt  output  1 each`: one-hot instruction lines.
- `c`, `z  output  1 each`: latched carry and zero flags.
- `illegal  output  1`: undefined opcode decoded in the current EXEC.
- `icnt  output  CNT_W`: count of retired instructions.

## Operation
- States:
  - FETCH: `sm`=0.
  - EXEC: `sm`=1.
  - HALT: `sm`=1.
- Transitions:
  - FETCH → EXEC every cycle.
  - EXEC → FETCH, except that a decoded halt goes to HALT.
  - HALT → FETCH on `start`=1; otherwise HALT holds.
  - `start` is ignored in FETCH and EXEC.
- Decode uses opcode `ir[7:4]` and is valid only in EXEC. In FETCH all instruction lines are 0.
  - 0000 nop; 0001 halt; 0010 in1; 0011 out1.
  - 0100 jump group on `ir[3:2]`: 00 jmp, 01 jz, 10 jc, 11 illegal.
  - 0101 not1; 0110 sub; 1001 add; 1010 rsr; 1011 and1; 1100 rsl.
  - 0111 mov group:
    - `ir[3:2]`=11 gives movb.
    - otherwise `ir[1:0]`=11 gives movc.
    - otherwise mova.
    - `ir`=0111_1111 decodes as movb.
  - 1000, 1101, 1110 and 1111 are illegal.
- Illegal opcode: no instruction line is asserted except as set by the macro (see Configuration), and `illegal`=1 for that EXEC.
- In HALT, `halt`=1 and every other line is 0.
- Flags: at the rising edge that ends EXEC, `c` ← `alu_cf` if `cf_en` and `z` ← `alu_zf` if `zf_en`. Otherwise the flags hold. `cf_en`/`zf_en` are ignored outside EXEC.
- `icnt` increments by 1 at every EXEC → FETCH or EXEC → HALT edge, and wraps from all-ones to 0.
- At most one instruction line is asserted in any cycle.

## Timing
- Reset (async, on `rst_n` falling):
  - state = FETCH, `sm`=0.
  - `c`=0, `z`=0, `icnt`=0, `illegal`=0.
  - all instruction lines = 0.
- Release is synchronous to the next `clk` edge. The first edge after release enters EXEC.
- Instruction lines and `illegal` are combinational from state and `ir`. They are valid for the whole EXEC cycle with no added latency.
- `sm`, `c`, `z` and `icnt` are registered outputs.
- Flag latency:
  - A flag written in EXEC n is visible from FETCH n+1.
  - `jz`/`jc` in EXEC n+1 therefore see the flags written by instruction n.
- A `start` pulse in HALT: FETCH starts on the next cycle, and EXEC follows one cycle after that.
- Start-and-flag coincidence: `start` asserted on the same edge that enters HALT is ignored, because the machine was in EXEC on that edge.
- Reset mid-EXEC aborts the instruction:
  - The flags are not written.
  - `icnt` is not incremented.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in EXEC transitions to HALT, exactly as halt does.
  - `illegal`=1 during that EXEC.
  - The instruction lines stay 0 in that EXEC, and `halt`=1 from the following cycle onward.
- `ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode decodes as `nop`=1.
  - `illegal` is tied to 0.
  - Sequencing continues normally.

## Test plan
- Reset, then run with `ir`=0x90 (add), `alu_cf`=1, `alu_zf`=0, `cf_en`=`zf_en`=1 → `sm` goes 0,1,0,1; `add`=1 only when `sm`=1; after the first EXEC, `c`=1, `z`=0, `icnt`=1.
- Flag-conditional jump:
  - Latch `z`=1, then EXEC with `ir`=0x44 → `jz`=1 and `jc`=0.
  - With `ir`=0x48 and `c`=0 → `jc`=1, and `c` is unchanged because `cf_en`=0.
- Mov group:
  - `ir`=0x74 → mova.
  - `ir`=0x7C → movb.
  - `ir`=0x73 → movc.
  - `ir`=0x7F → movb.
  - Each asserts only in EXEC.
- Halt and resume:
  - `ir`=0x10 → HALT; `halt` held for 20 cycles; `sm`=1; `icnt` frozen.
  - A `start` pulse → FETCH next cycle, then EXEC.
- Illegal opcode `ir`=0xE0:
  - With `ILLEGAL_TRAP_EN` → `illegal`=1 and the block enters HALT.
  - Without it → `nop`=1, `illegal`=0, and execution continues.
- Counter wrap and reset mid-op:
  - Preload via `CNT_W`=4 and run 16 instructions → `icnt` wraps to 0.
  - `rst_n`=0 mid-EXEC → all outputs are 0 immediately.
